ex_stage: RTL

- Execute stage that consumes the ID/EX pipeline register outputs and produces the registered EX/MEM result bundle.
- Single-cycle ALU ops complete in one clock.
- MUL, DIVU and REMU use a 32-iteration sequential engine. While it runs, the block asserts stall back to IF/ID and ID/EX, which hold their contents.
- All state updates on negedge clock, matching the pipeline registers.

---
 rtl/ex_stage.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage between the ID/EX and EX/MEM pipeline registers.
//
// Single-cycle ALU ops (ALUOp 0-12) register their result one falling edge
// after they are presented. MUL, DIVU and REMU (13-15) run on a sequential
// engine that retires one bit per falling edge. While the engine runs,
// 'stall' holds IF/ID and ID/EX. All state changes on the falling clock edge.
//
// Ports:
//   clock, reset_n       falling-edge clock, asynchronous active-low reset
//   flush                synchronous kill of the current/in-flight operation
//   valid_in             ID/EX holds a valid instruction
//   registerFileDataA/B  operands (B register form)
//   extendedSignal       extended immediate, chosen as B when useImm=1
//   pcpp                 PC+4, result of JAL
//   ALUOp                operation code (16-31 are NOPs)
//   registerFileWrite    destination register index
//   stall                combinational hold request to upstream registers
//   aluResult, writeReg  registered result bundle
//   valid_out            registered; result bundle must be written back
module ex_stage #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] registerFileDataA,
  input  logic [WIDTH-1:0] registerFileDataB,
  input  logic [WIDTH-1:0] extendedSignal,
  input  logic [WIDTH-1:0] pcpp,
  input  logic             useImm,
  input  logic [4:0]       ALUOp,
  input  logic [4:0]       registerFileWrite,
  output logic             stall,
  output logic [WIDTH-1:0] aluResult,
  output logic [4:0]       writeReg,
  output logic             valid_out
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3,  OP_XOR  = 5'd4,  OP_NOR  = 5'd5;
  localparam logic [4:0] OP_SLT  = 5'd6,  OP_SLTU = 5'd7,  OP_SLL  = 5'd8;
  localparam logic [4:0] OP_SRL  = 5'd9,  OP_SRA  = 5'd10, OP_LUI  = 5'd11;
  localparam logic [4:0] OP_JAL  = 5'd12, OP_MUL  = 5'd13, OP_DIVU = 5'd14;
  localparam logic [4:0] OP_REMU = 5'd15;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [4:0]       op_q, op_d;
  // Engine registers. MUL: x = shifting multiplicand, y = shifting
  // multiplier, acc = partial product. DIVU/REMU: x = dividend shifting out
  // while quotient bits shift in, y = divisor, acc = partial remainder.
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [4:0]       dst_q, dst_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [4:0]       wreg_q, wreg_d;
  logic             vld_q, vld_d;

  logic [WIDTH-1:0] op_a, op_b, alu_single;
  logic [SHW-1:0]   shamt;
  logic             is_single, is_multi;
  logic [WIDTH-1:0] mul_acc, div_quo, div_rem;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;

  assign op_a      = registerFileDataA;
  assign op_b      = useImm ? extendedSignal : registerFileDataB;
  assign shamt     = op_b[SHW-1:0];
  assign is_single = (ALUOp <= OP_JAL);
  assign is_multi  = (ALUOp inside {OP_MUL, OP_DIVU, OP_REMU});

  always_comb begin
    alu_single = '0;
    case (ALUOp)
      OP_ADD:  alu_single = op_a + op_b;
      OP_SUB:  alu_single = op_a - op_b;
      OP_AND:  alu_single = op_a & op_b;
      OP_OR:   alu_single = op_a | op_b;
      OP_XOR:  alu_single = op_a ^ op_b;
      OP_NOR:  alu_single = ~(op_a | op_b);
      OP_SLT:  alu_single = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_single = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      OP_SLL:  alu_single = op_a << shamt;
      OP_SRL:  alu_single = op_a >> shamt;
      OP_SRA:  alu_single = $unsigned($signed(op_a) >>> shamt);
      OP_LUI:  alu_single = op_b << 16;
      OP_JAL:  alu_single = pcpp;
      default: alu_single = '0;
    endcase
  end

  // One engine step. Shift-add: add the multiplicand when the current
  // multiplier bit is set. Restoring division: shift the next dividend bit
  // into the remainder and subtract the divisor when it fits. With a zero
  // divisor every trial fits, so the quotient fills with ones and the
  // remainder ends up holding the dividend.
  assign mul_acc   = acc_q + (y_q[0] ? x_q : '0);
  assign div_trial = {acc_q, x_q[WIDTH-1]};
  assign div_ge    = (div_trial >= {1'b0, y_q});
  assign div_rem   = div_ge ? (div_trial[WIDTH-1:0] - y_q) : div_trial[WIDTH-1:0];
  assign div_quo   = {x_q[WIDTH-2:0], div_ge};

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned, which would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    dst_d   = dst_q;
    res_d   = res_q;
    wreg_d  = wreg_q;
    vld_d   = 1'b0;

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_in && is_single) begin
            res_d  = alu_single;
            wreg_d = registerFileWrite;
            vld_d  = 1'b1;
          end else if (valid_in && is_multi) begin
            op_d    = ALUOp;
            x_d     = op_a;
            y_d     = op_b;
            acc_d   = '0;
            dst_d   = registerFileWrite;
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
        BUSY: begin
          cnt_d = cnt_q + 1'b1;
          if (op_q == OP_MUL) begin
            acc_d = mul_acc;
            x_d   = x_q << 1;
            y_d   = y_q >> 1;
          end else begin
            acc_d = div_rem;
            x_d   = div_quo;
          end
          if (cnt_q == LAST) begin
            case (op_q)
              OP_MUL:  res_d = mul_acc;
              OP_DIVU: res_d = div_quo;
              default: res_d = div_rem;
            endcase
            wreg_d  = dst_q;
            vld_d   = 1'b1;
            cnt_d   = '0;
            state_d = DONE;
          end
        end
        // Inputs still show the completed instruction here; ignore them.
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      dst_q   <= '0;
      res_q   <= '0;
      wreg_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      dst_q   <= dst_d;
      res_q   <= res_d;
      wreg_q  <= wreg_d;
      vld_q   <= vld_d;
    end
  end

  // Gated by reset_n so upstream is never held while the stage is in reset.
  assign stall = reset_n &&
                 ((state_q == BUSY) || ((state_q == IDLE) && valid_in && is_multi));

  assign aluResult = res_q;
  assign writeReg  = wreg_q;
  assign valid_out = vld_q;

endmodule
